// File: rtl/sat_narrow_if.sv
// Stream + status bundle for sat_narrow.
// slave  = block side (consumes data_in, produces data_out).
// master = driver/sink side.
interface sat_narrow_if #(
  parameter int LENGTH_IN  = 20,
  parameter int LENGTH_OUT = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LENGTH_IN-1:0]  data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [LENGTH_OUT-1:0] data_out;
  logic                  sat_flag;
  logic                  sat_clr;
  logic [15:0]           sat_count;

  modport slave (
    input  in_valid, data_in, out_ready, sat_clr,
    output in_ready, out_valid, data_out, sat_flag, sat_count
  );

  modport master (
    output in_valid, data_in, out_ready, sat_clr,
    input  in_ready, out_valid, data_out, sat_flag, sat_count
  );
endinterface

// File: rtl/sat_narrow.sv
// sat_narrow: two-stage narrowing pipe. Stage 1 drops SHIFT LSBs with one
// guard bit, stage 2 saturates to LENGTH_OUT bits and flags clipping.
// Both stages stall together when the output is held by the sink.
// Optional build macro SAT_NARROW_ROUND_EN: round half up in stage 1
// instead of truncating.
module sat_narrow #(
  parameter int LENGTH_IN  = 20,
  parameter int LENGTH_OUT = 16,
  parameter int SHIFT      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sat_narrow_if.slave   bus
);
  localparam int STAGES = 2;
  // Stage-1 width: shifted value plus one guard bit, so rounding can't wrap.
  localparam int W1     = LENGTH_IN - SHIFT + 1;
  localparam int HI_W   = W1 - LENGTH_OUT + 1;
  localparam logic [LENGTH_OUT-1:0] MAXV = {1'b0, {(LENGTH_OUT-1){1'b1}}};
  localparam logic [LENGTH_OUT-1:0] MINV = {1'b1, {(LENGTH_OUT-1){1'b0}}};
`ifdef SAT_NARROW_ROUND_EN
  localparam logic [LENGTH_IN:0] RND = (LENGTH_IN+1)'(1) << (SHIFT-1);
`endif

  if ((LENGTH_IN - SHIFT < LENGTH_OUT) || (SHIFT < 1)) begin : g_bad_cfg
    $error("sat_narrow: need LENGTH_IN-SHIFT >= LENGTH_OUT and SHIFT >= 1");
  end

  logic                  stall;
  logic                  adv;
  logic [STAGES:1]       vld_pipe_d, vld_pipe_q;
  logic [LENGTH_IN:0]    ext;
  logic [SHIFT-1:0]      unused_lsbs;
  logic [W1-1:0]         s1_shift;
  logic [W1-1:0]         s1_data_d, s1_data_q;
  logic [HI_W-1:0]       hi;
  logic                  clip;
  logic [LENGTH_OUT-1:0] data_out_d, data_out_q;
  logic                  sat_flag_d, sat_flag_q;
  logic [15:0]           sat_count_d, sat_count_q;

  // Whole pipe freezes only when a valid result is refused downstream.
  always_comb begin
    stall = vld_pipe_q[STAGES] & ~bus.out_ready;
    adv   = ~stall;
  end

  // Valid shift register: bubbles travel with the data, no compaction.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (adv) vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.in_valid};
  end

  // Stage 1: sign-extend by one bit, optionally add half an LSB, then drop
  // SHIFT LSBs (slicing the top bits is the arithmetic shift).
  always_comb begin
    ext = {bus.data_in[LENGTH_IN-1], bus.data_in};
`ifdef SAT_NARROW_ROUND_EN
    ext = ext + RND;
`endif
    s1_shift    = ext[LENGTH_IN:SHIFT];
    unused_lsbs = ext[SHIFT-1:0];
    s1_data_d   = adv ? s1_shift : s1_data_q;
  end

  // Stage 2: in range iff every bit from the output sign bit upward agrees.
  always_comb begin
    hi         = s1_data_q[W1-1:LENGTH_OUT-1];
    clip       = ~((&hi) | ~(|hi));
    data_out_d = data_out_q;
    sat_flag_d = sat_flag_q;
    if (adv) begin
      if (clip) data_out_d = hi[HI_W-1] ? MINV : MAXV;
      else      data_out_d = s1_data_q[LENGTH_OUT-1:0];
      // Flag only meaningful with a real sample; keep it low on bubbles.
      sat_flag_d = clip & vld_pipe_q[1];
    end
  end

  // Clip counter: one count per delivered clipped sample, sticks at max,
  // clear wins. A stalled sample is only counted on the edge it leaves.
  always_comb begin
    sat_count_d = sat_count_q;
    if (bus.sat_clr)
      sat_count_d = '0;
    else if (vld_pipe_q[STAGES] && bus.out_ready && sat_flag_q &&
             (sat_count_q != 16'hFFFF))
      sat_count_d = sat_count_q + 16'd1;
  end

  // Pipeline state; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      s1_data_q   <= '0;
      data_out_q  <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      s1_data_q   <= s1_data_d;
      data_out_q  <= data_out_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.in_ready  = ~stall;
    bus.out_valid = vld_pipe_q[STAGES];
    bus.data_out  = data_out_q;
    bus.sat_flag  = sat_flag_q;
    bus.sat_count = sat_count_q;
  end
endmodule

// File: doc/sat_narrow.md
SAT_NARROW -- requirements
Module: sat_narrow

Interface
REQ-001 SHALL have parameter LENGTH_IN, default 20: signed input sample width.
REQ-002 SHALL have parameter LENGTH_OUT, default 16: signed output sample width.
REQ-003 SHALL have parameter SHIFT, default 2: LSBs discarded before saturation; legal only if LENGTH_IN-SHIFT >= LENGTH_OUT and SHIFT >= 1.
REQ-004 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: data_in holds a sample.
REQ-007 SHALL have port in_ready, output, 1: block accepts data_in this cycle.
REQ-008 SHALL have port data_in, input, LENGTH_IN: two's-complement sample.
REQ-009 SHALL have port out_valid, output, 1: data_out holds a result.
REQ-010 SHALL have port out_ready, input, 1: sink accepts data_out this cycle.
REQ-011 SHALL have port data_out, output, LENGTH_OUT: narrowed two's-complement sample.
REQ-012 SHALL have port sat_flag, output, 1: current data_out was clipped; qualified by out_valid.
REQ-013 SHALL have port sat_clr, input, 1: synchronous clear of sat_count.
REQ-014 SHALL have port sat_count, output, 16: number of clipped samples delivered.

Function
REQ-015 SHALL transfer a sample on any edge where valid and ready are both high, per port pair.
REQ-016 SHALL use a two-stage pipeline: stage 1 = shift (and round), stage 2 = saturate; latency exactly 2 clocks from input transfer to out_valid, with no stall.
REQ-017 SHALL define stall = out_valid AND NOT out_ready; in_ready = NOT stall; both stages hold contents while stall, advance together otherwise.
REQ-018 SHALL propagate bubbles (stage valid bits) without compaction; a stage with valid=0 loads whatever is upstream on advance.
REQ-019 SHALL hold data_out, sat_flag, out_valid stable while stall.
REQ-020 SHALL compute stage 1 as arithmetic right shift of data_in by SHIFT, kept at LENGTH_IN-SHIFT+1 bits (one guard bit).
REQ-021 SHALL saturate in stage 2: value > 2^(LENGTH_OUT-1)-1 -> 2^(LENGTH_OUT-1)-1, value < -2^(LENGTH_OUT-1) -> -2^(LENGTH_OUT-1), else low LENGTH_OUT bits; sat_flag=1 only when clipped.
REQ-022 SHALL increment sat_count by 1 on each output transfer with sat_flag=1, sticking at 0xFFFF (no wrap).
REQ-023 SHALL clear sat_count to 0 when sat_clr=1; clear takes precedence over a simultaneous saturated transfer.
REQ-024 SHALL NOT count a clipped sample held during stall more than once.

Reset
REQ-025 SHALL, while rst_n=0, force out_valid=0, sat_flag=0, data_out=0, sat_count=0, all stage valid bits 0; in_ready=1 after reset.
REQ-026 SHALL discard in-flight samples on reset assertion mid-operation; first output after release comes only from a post-reset input transfer.

Configuration
REQ-027 SHALL, with macro SAT_NARROW_ROUND_EN defined, add 2^(SHIFT-1) to data_in (sign-extended by one bit) before the shift in stage 1 (round half up), latency unchanged.
REQ-028 SHALL, without SAT_NARROW_ROUND_EN, truncate (floor) with no adder present.

Verification (LENGTH_IN=20, LENGTH_OUT=16, SHIFT=2)
REQ-029 SHALL cover: data_in=0x01000, out_ready=1 -> 2 clocks later data_out=0x0400, sat_flag=0, sat_count unchanged.
REQ-030 SHALL cover: data_in=0x7FFFF then 0x80000 -> data_out=0x7FFF then 0x8000, sat_flag=1 both, sat_count=2.
REQ-031 SHALL cover: data_in=0x00006 and 0xFFFFA -> truncating build 0x0001, 0xFFFE; SAT_NARROW_ROUND_EN build 0x0002, 0xFFFF.
REQ-032 SHALL cover: out_ready=0 for 5 cycles with clipped sample at output -> in_ready=0, data_out stable, sat_count increments exactly once after out_ready=1.
REQ-033 SHALL cover: sat_clr=1 in same cycle as clipped transfer -> sat_count=0; 65536 clipped samples after clear -> sat_count=0xFFFF.
REQ-034 SHALL cover: rst_n pulsed low with two samples in flight -> out_valid=0 immediately, no stale sample emitted after release.
